// File: rtl/vl_element_sequencer.sv
// vl_element_sequencer
// Latches the vector length on an accepted start and walks the vector in
// groups of NUMLANES elements, one group per accepted beat, then pulses done.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         synchronous active-high reset
//   start         begin sequencing (sampled only in IDLE)
//   vl            vector length, sampled on an accepted start
//   stall         downstream not ready; current beat is held
//   busy          high while beats are being issued (RUN)
//   out_valid     beat outputs valid
//   out_elem_base element index of lane 0 for this beat
//   out_lane_en   per-lane enable, bit i set iff base+i < latched vl
//   out_last      final beat of the vector
//   done          one-cycle completion pulse (also for vl==0)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | presenting beats, advancing on out_valid && !stall
// FIN   | done pulse for one cycle, start ignored
module vl_element_sequencer #(
  parameter int NUMLANES     = 8,
  parameter int LOG2NUMLANES = 3,
  parameter int VLWIDTH      = 32,
  parameter int MVL          = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [VLWIDTH-1:0]  vl,
  input  logic                stall,
  output logic                busy,
  output logic                out_valid,
  output logic [VLWIDTH-1:0]  out_elem_base,
  output logic [NUMLANES-1:0] out_lane_en,
  output logic                out_last,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [VLWIDTH:0] MVL_EXT   = (VLWIDTH+1)'(MVL);
  localparam logic [VLWIDTH:0] LANES_EXT = (VLWIDTH+1)'(NUMLANES);

  state_t             state_q, state_d;
  logic [VLWIDTH:0]   base_q, base_d;
  logic [VLWIDTH:0]   vlat_q, vlat_d;
  logic [VLWIDTH:0]   vl_ext;
  logic               last_c;
  logic [NUMLANES-1:0] lane_en_c;
  logic               accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      vlat_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      vlat_q  <= vlat_d;
    end
  end

  // Beat contents depend only on registered state, so start/vl/stall
  // never reach the outputs combinationally.
  always_comb begin
    lane_en_c = '0;
    last_c    = 1'b0;
    if (state_q == RUN) begin
      last_c = (base_q + LANES_EXT) >= vlat_q;
      for (int i = 0; i < NUMLANES; i++) begin
        lane_en_c[i] = (base_q + (VLWIDTH+1)'(i)) < vlat_q;
      end
    end
  end

  assign accept = (state_q == RUN) && !stall;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    vlat_d  = vlat_q;
    vl_ext  = {1'b0, vl};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vlat_d  = (vl_ext > MVL_EXT) ? MVL_EXT : vl_ext;
          base_d  = '0;
          state_d = (vl_ext == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_c) begin
            state_d = FIN;
          end else begin
            base_d = base_q + LANES_EXT;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy          = (state_q == RUN);
  assign out_valid     = (state_q == RUN);
  assign out_elem_base = base_q[VLWIDTH-1:0];
  assign out_lane_en   = lane_en_c;
  assign out_last      = last_c;
  assign done          = (state_q == FIN);

endmodule

// File: tb/tb_vl_element_sequencer.sv
module tb_vl_element_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] vl;
  logic        stall;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_elem_base;
  logic [7:0]  out_lane_en;
  logic        out_last;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  vl_element_sequencer #(
    .NUMLANES(8), .LOG2NUMLANES(3), .VLWIDTH(32), .MVL(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .vl(vl), .stall(stall),
    .busy(busy), .out_valid(out_valid), .out_elem_base(out_elem_base),
    .out_lane_en(out_lane_en), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // busy, valid, base, lane_en, last, done
  task automatic chk_all(input string tag, input logic b, input logic v,
                         input logic [31:0] base, input logic [7:0] en,
                         input logic l, input logic d);
    chk({tag, ".busy"},  64'(busy),          64'(b));
    chk({tag, ".valid"}, 64'(out_valid),     64'(v));
    chk({tag, ".done"},  64'(done),          64'(d));
    if (v) begin
      chk({tag, ".base"}, 64'(out_elem_base), 64'(base));
      chk({tag, ".en"},   64'(out_lane_en),   64'(en));
      chk({tag, ".last"}, 64'(out_last),      64'(l));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vl = '0; stall = 1'b0;
    tick(); tick();
    chk_all("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.base", 64'(out_elem_base), 64'd0);
    chk("rst.en",   64'(out_lane_en),   64'd0);
    chk("rst.last", 64'(out_last),      64'd0);
    reset = 1'b0;
    tick();

    // vl=16: two full beats
    start = 1'b1; vl = 32'd16;
    tick(); start = 1'b0;
    chk_all("v16.b0", 1, 1, 0, 8'hFF, 0, 0);
    tick();
    chk_all("v16.b1", 1, 1, 8, 8'hFF, 1, 0);
    tick();
    chk_all("v16.done", 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("v16.idle", 0, 0, 0, 0, 0, 0);

    // vl=13: partial last beat; vl changes after acceptance
    start = 1'b1; vl = 32'd13;
    tick(); start = 1'b0; vl = 32'd100;
    chk_all("v13.b0", 1, 1, 0, 8'hFF, 0, 0);
    tick();
    chk_all("v13.b1", 1, 1, 8, 8'h1F, 1, 0);
    tick();
    chk_all("v13.done", 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("v13.idle", 0, 0, 0, 0, 0, 0);

    // vl=0: no beats, done at +1
    start = 1'b1; vl = 32'd0;
    tick(); start = 1'b0;
    chk_all("v0.done", 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("v0.idle", 0, 0, 0, 0, 0, 0);

    // vl=200 clamps to 64: 8 beats
    start = 1'b1; vl = 32'd200;
    tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_all($sformatf("v200.b%0d", k), 1, 1, 32'(8*k), 8'hFF, (k == 7), 0);
      tick();
    end
    chk_all("v200.done", 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("v200.idle", 0, 0, 0, 0, 0, 0);

    // vl=24 with stall on the second beat, stray start mid-vector
    start = 1'b1; vl = 32'd24;
    tick(); start = 1'b0;
    chk_all("v24.b0", 1, 1, 0, 8'hFF, 0, 0);
    tick();
    chk_all("v24.b1a", 1, 1, 8, 8'hFF, 0, 0);
    stall = 1'b1;
    tick();
    chk_all("v24.b1b", 1, 1, 8, 8'hFF, 0, 0);
    start = 1'b1; vl = 32'd8;
    tick(); start = 1'b0;
    chk_all("v24.b1c", 1, 1, 8, 8'hFF, 0, 0);
    tick();
    chk_all("v24.b1d", 1, 1, 8, 8'hFF, 0, 0);
    stall = 1'b0;
    tick();
    chk_all("v24.b2", 1, 1, 16, 8'hFF, 1, 0);
    tick();
    chk_all("v24.done", 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("v24.idle", 0, 0, 0, 0, 0, 0);

    // reset during second beat of vl=32
    start = 1'b1; vl = 32'd32;
    tick(); start = 1'b0;
    chk_all("v32.b0", 1, 1, 0, 8'hFF, 0, 0);
    tick();
    chk_all("v32.b1", 1, 1, 8, 8'hFF, 0, 0);
    reset = 1'b1;
    tick();
    chk_all("v32.rst", 0, 0, 0, 0, 0, 0);
    chk("v32.rst.base", 64'(out_elem_base), 64'd0);
    reset = 1'b0;
    tick();
    chk_all("v32.nodone", 0, 0, 0, 0, 0, 0);

    start = 1'b1; vl = 32'd8;
    tick(); start = 1'b0;
    chk_all("v8.b0", 1, 1, 0, 8'hFF, 1, 0);
    tick();
    chk_all("v8.done", 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("v8.idle", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  always @(negedge clk) begin
    if (!reset && done && out_valid) begin
      n_bad++;
      $error("FAIL done_valid_overlap: observed done=1 valid=1 expected not both");
    end
  end

endmodule

// File: doc/vl_element_sequencer.md
Name: vl_element_sequencer

Overview:
- Sits directly downstream of the vector control register file and consumes its `vl` output.
- On each vector-instruction start it latches `vl` and walks the vector in groups of NUMLANES elements, one group per accepted beat.
- For every group it emits the element base index, a per-lane enable mask and a last flag to the lane datapath.
- It honours a downstream stall and pulses `done` when the final group has been accepted.

Parameters:
- NUMLANES, 8, number of vector lanes (elements per beat); power of two.
- LOG2NUMLANES, 3, log2(NUMLANES).
- VLWIDTH, 32, width of the incoming `vl` value.
- MVL, 64, maximum vector length; larger `vl` values are clamped to this.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin sequencing; sampled only in IDLE.
- vl  input  VLWIDTH  vector length from the control register file, sampled on an accepted start.
- stall  input  1  downstream not ready; the current beat is held while this is high.
- busy  output  1  high from the cycle after an accepted start until `done` is asserted.
- out_valid  output  1  beat outputs are valid.
- out_elem_base  output  VLWIDTH  index of lane 0's element for this beat.
- out_lane_en  output  NUMLANES  bit i high iff out_elem_base+i < latched vl.
- out_last  output  1  current beat is the final beat of the vector.
- done  output  1  one-cycle pulse: the vector has completed (including vl==0).

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, out_valid=0, out_elem_base=0, out_lane_en=0, out_last=0, done=0; latched vl=0. Reset asserted mid-RUN aborts the vector immediately: no done pulse, the in-flight beat is dropped.
- States: IDLE, RUN, FIN.
- IDLE:
  - Accept start only here. Latch vlat = min(vl, MVL); comparison uses the full VLWIDTH.
  - If vlat==0: go to FIN. No beat is ever valid for that vector.
  - Otherwise go to RUN and present the first beat in the next cycle: out_valid=1, base=0.
  - Latency: start at cycle N gives the first out_valid at N+1.
- RUN:
  - A beat is accepted when out_valid && !stall.
  - While stall=1, out_elem_base, out_lane_en and out_last are held stable and out_valid stays 1.
  - On accept with out_last=0: base += NUMLANES; the next beat is valid in the following cycle, with no bubble.
  - On accept with out_last=1: out_valid drops to 0 in the next cycle and the state goes to FIN.
- FIN: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE. A start arriving during FIN is ignored; it is accepted again from the IDLE cycle.
- Beat contents:
  - out_last = (base + NUMLANES >= vlat).
  - out_lane_en is all ones except on the last beat when vlat is not a multiple of NUMLANES. In that case only the low (vlat mod NUMLANES) bits are set.
- Beat count = ceil(vlat/NUMLANES).
- Arithmetic: base is computed in VLWIDTH+1 bits internally, so base+NUMLANES cannot overflow for MVL near 2^VLWIDTH.
- start while busy (RUN or FIN) is ignored; no queuing. A change on `vl` after acceptance has no effect on the running vector.
- Combinational paths: no combinational path from start or vl to any output. stall affects only the next-cycle state, never the current beat's outputs.
- done and out_valid are never high in the same cycle.

Test Plan:
- Reset, then start with vl=16, NUMLANES=8, stall=0 -> beats at cycles +1 and +2 with base 0/8, lane_en 0xFF/0xFF, last 0/1; done pulse at +3; busy high for +1..+2.
- start with vl=13 -> 2 beats: base 0 with lane_en 0xFF and last=0, then base 8 with lane_en 0x1F and last=1; done follows.
- start with vl=0 -> no out_valid at all; done pulses once at cycle +1; busy stays 0.
- start with vl=200, MVL=64 -> exactly 8 beats (bases 0..56 step 8), all lane_en=0xFF, last on base=56.
- vl=24 with stall held high for 3 cycles on the second beat -> base=8 is held stable for 4 cycles, then base=16 follows; total 3 accepted beats; a second start pulsed mid-vector is ignored.
- Reset asserted during the second beat of a vl=32 vector -> next cycle out_valid=0, busy=0, no done pulse; a new start with vl=8 then produces a single beat with lane_en=0xFF and last=1.
